// File: rtl/wormhole_switch_scheduler.sv
// Wormhole switch scheduler: per-output round-robin arbitration on head flits,
// packet-granular output locking and downstream credit tracking.
module wormhole_switch_scheduler #(
    parameter int AGENTS_NUM    = 5,
    parameter int RESOURCES_NUM = 5,
    parameter int BUFFER_SIZE   = 8,
    localparam int PW = (RESOURCES_NUM > 1) ? $clog2(RESOURCES_NUM) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [AGENTS_NUM-1:0]                        req_valid_i,
    input  logic [AGENTS_NUM-1:0][PW-1:0]                req_port_i,
    input  logic [AGENTS_NUM-1:0]                        req_head_i,
    input  logic [AGENTS_NUM-1:0]                        req_tail_i,
    input  logic [RESOURCES_NUM-1:0]                     credit_return_i,
    output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]     grants_o,
    output logic [RESOURCES_NUM-1:0]                     locked_o,
    output logic                                         credit_err_o
);
    localparam int AW = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic [RESOURCES_NUM-1:0][AW-1:0]            owner_q;
    logic [RESOURCES_NUM-1:0][AW-1:0]            ptr_q;
    logic [RESOURCES_NUM-1:0][CW-1:0]            credits_q;
    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    targets;
    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    grant;
    logic [AGENTS_NUM-1:0]                       owns_any;
    logic [RESOURCES_NUM-1:0]                    col_grant;
    logic [RESOURCES_NUM-1:0][AW-1:0]            winner;
    logic                                        found;
    int unsigned                                 idx;

    always_comb begin
        targets  = '0;
        owns_any = '0;
        for (int unsigned i = 0; i < AGENTS_NUM; i++) begin
            for (int unsigned r = 0; r < RESOURCES_NUM; r++) begin
                targets[i][r] = req_valid_i[i] && (req_port_i[i] == PW'(r));
                if (locked_o[r] && owner_q[r] == AW'(i))
                    owns_any[i] = 1'b1;
            end
        end
    end

    // Locked outputs serve only their owner; free outputs run a wrapping
    // search from the per-output pointer over head flits of non-owners.
    always_comb begin
        grant     = '0;
        col_grant = '0;
        winner    = '0;
        found     = 1'b0;
        idx       = 0;
        if (!rst) begin
            for (int unsigned r = 0; r < RESOURCES_NUM; r++) begin
                found = 1'b0;
                if (credits_q[r] != '0) begin
                    if (locked_o[r]) begin
                        for (int unsigned i = 0; i < AGENTS_NUM; i++) begin
                            if (owner_q[r] == AW'(i) && targets[i][r]) begin
                                grant[i][r]  = 1'b1;
                                col_grant[r] = 1'b1;
                                winner[r]    = AW'(i);
                            end
                        end
                    end else begin
                        for (int unsigned k = 0; k < AGENTS_NUM; k++) begin
                            idx = (32'(ptr_q[r]) + k) % AGENTS_NUM;
                            if (!found && targets[idx][r] && req_head_i[idx] && !owns_any[idx]) begin
                                found          = 1'b1;
                                grant[idx][r]  = 1'b1;
                                col_grant[r]   = 1'b1;
                                winner[r]      = AW'(idx);
                            end
                        end
                    end
                end
            end
        end
    end

    assign grants_o = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_o     <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            credit_err_o <= 1'b0;
            for (int unsigned r = 0; r < RESOURCES_NUM; r++)
                credits_q[r] <= CW'(BUFFER_SIZE);
        end else begin
            for (int unsigned r = 0; r < RESOURCES_NUM; r++) begin
                if (col_grant[r]) begin
                    if (req_tail_i[winner[r]]) begin
                        locked_o[r] <= 1'b0;
                    end else if (req_head_i[winner[r]]) begin
                        locked_o[r] <= 1'b1;
                        owner_q[r]  <= winner[r];
                    end
                    if (!locked_o[r])
                        ptr_q[r] <= (winner[r] == AW'(AGENTS_NUM - 1)) ? '0 : winner[r] + 1'b1;
                end
                // A simultaneous grant and return cancel; a return into a full counter is an error.
                if (col_grant[r] && !credit_return_i[r]) begin
                    credits_q[r] <= credits_q[r] - 1'b1;
                end else if (!col_grant[r] && credit_return_i[r]) begin
                    if (credits_q[r] == CW'(BUFFER_SIZE))
                        credit_err_o <= 1'b1;
                    else
                        credits_q[r] <= credits_q[r] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wormhole_switch_scheduler.sv
// Scoreboard bench for wormhole_switch_scheduler: directed scenarios plus
// randomized packet traffic checked against a behavioural reference model.
module tb_wormhole_switch_scheduler;
    localparam int A  = 5;
    localparam int R  = 5;
    localparam int B  = 8;
    localparam int PW = 3;

    typedef struct {
        logic [A-1:0][R-1:0] g;
        logic [R-1:0]        lk;
        logic                err;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [A-1:0]            req_valid_i;
    logic [A-1:0][PW-1:0]    req_port_i;
    logic [A-1:0]            req_head_i;
    logic [A-1:0]            req_tail_i;
    logic [R-1:0]            credit_return_i;
    logic [A-1:0][R-1:0]     grants_o;
    logic [R-1:0]            locked_o;
    logic                    credit_err_o;

    // stimulus staging and model outputs
    logic                    rst_s;
    logic [A-1:0]            v_s, h_s, t_s;
    logic [A-1:0][PW-1:0]    p_s;
    logic [R-1:0]            cr_s;
    logic [A-1:0][R-1:0]     g_exp;

    // reference model state: owner -1 means the output is free
    int own_m[R];
    int ptr_m[R];
    int cred_m[R];
    bit err_m;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    wormhole_switch_scheduler #(
        .AGENTS_NUM(A),
        .RESOURCES_NUM(R),
        .BUFFER_SIZE(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_port_i(req_port_i),
        .req_head_i(req_head_i),
        .req_tail_i(req_tail_i),
        .credit_return_i(credit_return_i),
        .grants_o(grants_o),
        .locked_o(locked_o),
        .credit_err_o(credit_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit, tests=%0d", n_tests);
        $fatal(1);
    end

    function automatic void model_reset();
        for (int r = 0; r < R; r++) begin
            own_m[r]  = -1;
            ptr_m[r]  = 0;
            cred_m[r] = B;
        end
        err_m = 1'b0;
    endfunction

    function automatic bit owns(int i);
        for (int r = 0; r < R; r++)
            if (own_m[r] == i) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear();
        rst_s = 1'b0;
        v_s = '0; h_s = '0; t_s = '0; p_s = '0; cr_s = '0;
    endtask

    task automatic set_port(int port);
        for (int i = 0; i < A; i++) p_s[i] = PW'(port);
    endtask

    // Drive one cycle of stimulus, predict the response and advance the model.
    task automatic step();
        int   gi[R];
        exp_t e;
        @(negedge clk);
        rst             = rst_s;
        req_valid_i     = v_s;
        req_port_i      = p_s;
        req_head_i      = h_s;
        req_tail_i      = t_s;
        credit_return_i = cr_s;
        e.g = '0;
        for (int r = 0; r < R; r++) begin
            gi[r]   = -1;
            e.lk[r] = (own_m[r] >= 0);
        end
        e.err = err_m;
        if (!rst_s) begin
            for (int r = 0; r < R; r++) begin
                if (cred_m[r] > 0) begin
                    if (own_m[r] >= 0) begin
                        if (v_s[own_m[r]] && int'(p_s[own_m[r]]) == r) gi[r] = own_m[r];
                    end else begin
                        for (int k = 0; k < A; k++) begin
                            int i;
                            i = (ptr_m[r] + k) % A;
                            if (gi[r] < 0 && v_s[i] && int'(p_s[i]) == r && h_s[i] && !owns(i))
                                gi[r] = i;
                        end
                    end
                    if (gi[r] >= 0) e.g[gi[r]][r] = 1'b1;
                end
            end
        end
        q.push_back(e);
        g_exp = e.g;
        if (rst_s) begin
            model_reset();
        end else begin
            for (int r = 0; r < R; r++) begin
                if (gi[r] >= 0) begin
                    if (own_m[r] < 0) ptr_m[r] = (gi[r] + 1) % A;
                    if (t_s[gi[r]])      own_m[r] = -1;
                    else if (h_s[gi[r]]) own_m[r] = gi[r];
                    cred_m[r]--;
                end
                if (cr_s[r]) begin
                    if (gi[r] < 0 && cred_m[r] == B) err_m = 1'b1;
                    else cred_m[r]++;
                end
            end
        end
    endtask

    // Monitor: pops one prediction per cycle and compares the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_grants", 32'(grants_o), 32'(e.g));
                chk("sb_locked", 32'(locked_o), 32'(e.lk));
                chk("sb_err", 32'(credit_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        int sent;
        int pk_port[A];
        int pk_left[A];
        bit pk_first[A];

        model_reset();
        rst = 1'b1;
        req_valid_i = '0; req_port_i = '0; req_head_i = '0; req_tail_i = '0;
        credit_return_i = '0;
        clear();

        // reset state and wormhole locking on port 3
        rst_s = 1'b1; step(); #2;
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_err", 32'(credit_err_o), 0);
        chk("rst_grants", 32'(grants_o), 0);
        clear(); set_port(3);
        v_s = 5'b00111; h_s = 5'b00111; step(); #2;
        chk("t1_win0", 32'(grants_o[0]), 32'h08);
        chk("t1_lose12", 32'({grants_o[2], grants_o[1]}), 0);
        h_s = 5'b00110; step(); #2;
        chk("t1_locked", 32'(locked_o), 32'h08);
        chk("t1_body0", 32'(grants_o[0]), 32'h08);
        chk("t1_block12", 32'({grants_o[2], grants_o[1]}), 0);
        t_s = 5'b00001; step(); #2;
        chk("t1_tail0", 32'(grants_o[0]), 32'h08);
        v_s = 5'b00110; t_s = '0; step(); #2;
        chk("t1_next1", 32'(grants_o[1]), 32'h08);
        chk("t1_wait2", 32'(grants_o[2]), 0);
        h_s = 5'b00100; t_s = 5'b00010; step(); #2;
        chk("t1_tail1", 32'(grants_o[1]), 32'h08);
        v_s = 5'b00100; h_s = 5'b00100; t_s = 5'b00100; step(); #2;
        chk("t1_last2", 32'(grants_o[2]), 32'h08);

        // round-robin of single-flit packets on port 2
        clear(); rst_s = 1'b1; step();
        clear(); set_port(2);
        v_s = 5'b00111; h_s = 5'b00111; t_s = 5'b00111; step(); #2;
        chk("t2_g0", 32'(grants_o[0]), 32'h04);
        v_s = 5'b00110; step(); #2;
        chk("t2_g1", 32'(grants_o[1]), 32'h04);
        chk("t2_unlocked", 32'(locked_o[2]), 0);
        v_s = 5'b00100; step(); #2;
        chk("t2_g2", 32'(grants_o[2]), 32'h04);
        v_s = 5'b01001; h_s = 5'b01001; t_s = 5'b01001; step(); #2;
        chk("t2_ptr3", 32'(grants_o[3]), 32'h04);
        chk("t2_ptr3_not0", 32'(grants_o[0]), 0);
        chk("t2_never_locked", 32'(locked_o), 0);

        // credit exhaustion on port 0
        clear(); rst_s = 1'b1; step();
        clear(); sent = 0;
        for (int n = 0; n < 10; n++) begin
            v_s = 5'b10000; p_s[4] = 3'd0;
            h_s[4] = (sent == 0); t_s[4] = (sent == 9);
            step(); #2;
            chk("t3_stream", 32'(grants_o[4][0]), (n < 8) ? 1 : 0);
            if (g_exp[4][0]) sent++;
        end
        cr_s = 5'b00001; step(); #2;
        chk("t3_ret_cycle", 32'(grants_o[4][0]), 0);
        cr_s = '0; step(); #2;
        chk("t3_after_ret", 32'(grants_o[4][0]), 1);
        step(); #2;
        chk("t3_stall_again", 32'(grants_o[4][0]), 0);

        // grant+return cancel, overflow error flag
        clear(); rst_s = 1'b1; step();
        clear();
        v_s = 5'b00001; p_s[0] = 3'd1; h_s = 5'b00001; t_s = 5'b00001; cr_s = 5'b00010;
        step(); #2;
        chk("t4_grant_ret", 32'(grants_o[0]), 32'h02);
        clear(); step(); #2;
        chk("t4_no_err", 32'(credit_err_o), 0);
        cr_s = 5'b10000; step(); #2;
        chk("t4_err_reg", 32'(credit_err_o), 0);
        cr_s = '0; step(); #2;
        chk("t4_err_set", 32'(credit_err_o), 1);
        step(); step(); #2;
        chk("t4_err_sticky", 32'(credit_err_o), 1);
        sent = 0;
        for (int n = 0; n < 9; n++) begin
            v_s = 5'b00001; p_s[0] = 3'd1;
            h_s[0] = (sent == 0); t_s[0] = (sent == 8);
            step(); #2;
            chk("t4_full_count", 32'(grants_o[0][1]), (n < 8) ? 1 : 0);
            if (g_exp[0][1]) sent++;
        end

        // parallel grants and one-output-per-input
        clear(); rst_s = 1'b1; step();
        clear();
        v_s = 5'b01001; p_s[0] = 3'd1; p_s[3] = 3'd4; h_s = 5'b01001; step(); #2;
        chk("t5_g0", 32'(grants_o[0]), 32'h02);
        chk("t5_g3", 32'(grants_o[3]), 32'h10);
        v_s = 5'b00001; p_s[0] = 3'd2; h_s = 5'b00001; step(); #2;
        chk("t5_owner_blocked", 32'(grants_o[0]), 0);
        chk("t5_locks", 32'(locked_o), 32'h12);

        // reset mid-packet
        clear(); rst_s = 1'b1; step();
        clear(); set_port(3);
        for (int n = 0; n < 6; n++) begin
            v_s = 5'b00010; h_s = (n == 0) ? 5'b00010 : 5'b00000;
            step();
        end
        #2;
        chk("t6_locked_before", 32'(locked_o[3]), 1);
        rst_s = 1'b1; step(); #2;
        chk("t6_rst_grants", 32'(grants_o), 0);
        rst_s = 1'b0; v_s = 5'b00100; h_s = 5'b00100; step(); #2;
        chk("t6_unlocked", 32'(locked_o), 0);
        chk("t6_new_head", 32'(grants_o[2]), 32'h08);
        h_s = '0;
        for (int n = 0; n < 8; n++) begin
            step(); #2;
            chk("t6_credits_restored", 32'(grants_o[2][3]), (n < 7) ? 1 : 0);
        end

        // randomized packet traffic
        clear(); rst_s = 1'b1; step();
        for (int i = 0; i < A; i++) begin
            pk_left[i] = 0; pk_port[i] = 0; pk_first[i] = 1'b0;
        end
        for (int c = 0; c < 2000; c++) begin
            clear();
            rst_s = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < A; i++) begin
                if (pk_left[i] == 0 && $urandom_range(0, 2) == 0) begin
                    pk_port[i]  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(R, 7))
                                                               : int'($urandom_range(0, R - 1));
                    pk_left[i]  = int'($urandom_range(1, 4));
                    pk_first[i] = 1'b1;
                end
                v_s[i] = (pk_left[i] > 0) && ($urandom_range(0, 3) != 0);
                p_s[i] = PW'(pk_port[i]);
                h_s[i] = pk_first[i];
                t_s[i] = (pk_left[i] == 1);
            end
            for (int r = 0; r < R; r++) cr_s[r] = ($urandom_range(0, 2) == 0);
            step();
            for (int i = 0; i < A; i++) begin
                if (rst_s) begin
                    pk_left[i] = 0;
                end else if (v_s[i] && g_exp[i] != '0) begin
                    pk_left[i]--;
                    pk_first[i] = 1'b0;
                end else if (pk_port[i] >= R) begin
                    pk_left[i] = 0;
                end
            end
        end

        clear(); step(); step();
        #5;
        chk("sb_drain", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wormhole_switch_scheduler.md
Name: wormhole_switch_scheduler

Overview:
Credit-aware switch scheduler for one router. It shares RESOURCES_NUM output ports among AGENTS_NUM input ports at packet granularity.
- Free outputs are arbitrated round-robin on head flits.
- A granted output stays locked to its winning input until that input's tail flit is granted (wormhole).
- Per-output credit counters track downstream buffer space and block grants at zero credits.

Parameters:
AGENTS_NUM, 5, number of input ports (requesters)
RESOURCES_NUM, 5, number of output ports (resources)
BUFFER_SIZE, 8, downstream buffer depth per output = initial and maximum credit count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid_i  input  [AGENTS_NUM]  input i presents a flit this cycle
req_port_i  input  [AGENTS_NUM][$clog2(RESOURCES_NUM)]  requested output index, binary
req_head_i  input  [AGENTS_NUM]  presented flit is a head flit
req_tail_i  input  [AGENTS_NUM]  presented flit is a tail flit (head+tail = single-flit packet)
credit_return_i  input  [RESOURCES_NUM]  one-cycle pulse: downstream freed one slot of output r
grants_o  output  [AGENTS_NUM][RESOURCES_NUM]  grant matrix, combinational, same cycle as request
locked_o  output  [RESOURCES_NUM]  registered: output r is reserved by a packet in flight
credit_err_o  output  1  registered sticky flag: credit returned while counter already at BUFFER_SIZE

Behaviour:
- Reset state: locked=0, owner[r]=0, rr pointer[r]=0, credits[r]=BUFFER_SIZE, credit_err_o=0.
- grants_o is forced to all-zero while rst=1.
- Eligibility: input i targets r when req_valid_i[i] && req_port_i[i]==r. A req_port_i value >= RESOURCES_NUM is never granted.
- Free output r (locked=0, credits[r]>0):
  - Candidates are inputs targeting r with req_head_i=1 that do not own any locked output.
  - Round-robin: search starts at pointer[r] and wraps modulo AGENTS_NUM; the first candidate wins.
  - On that grant, pointer[r] <= winner+1 mod AGENTS_NUM. The pointer is unchanged when there is no grant.
- Locked output r (credits[r]>0):
  - Granted to owner[r] only, when the owner targets r.
  - req_head_i is ignored in this case.
  - All other inputs targeting r get no grant.
- Zero credits: no grant for r, regardless of lock state. Lock, owner and pointer are held.
- Lock update on a grant (i, r):
  - Head flit with tail=0: locked[r]<=1, owner[r]<=i.
  - Any flit with tail=1: locked[r]<=0.
  - A head+tail flit on a free output is granted without locking.
- Invariants:
  - At most one 1 per grants_o column.
  - At most one 1 per row.
  - An input owns at most one output.
- Credits: credits[r] <= credits[r] - grant_r + credit_return_i[r].
  - Grant and return in the same cycle leave the count unchanged.
  - A return at BUFFER_SIZE with no grant is dropped, the count stays BUFFER_SIZE, and credit_err_o is set until rst.
  - Counter width is $clog2(BUFFER_SIZE+1).
- Latency: grant in the request cycle. locked_o and credits reflect that grant from the next cycle.
- Owner deasserts req_valid_i mid-packet: the output stays locked and no grant is issued; it resumes when the owner returns.
- Reset mid-packet: all locks are dropped and credits are restored to BUFFER_SIZE the next cycle.

Test Plan:
1. Reset, then inputs 0, 1, 2 present head flits to port 3 (tail=0) at the same time → cycle 0 grants (0,3), locked_o[3]=1 from cycle 1. Inputs 1 and 2 receive no grant until input 0's tail flit is granted.
2. Round-robin: 3 back-to-back single-flit packets (head=tail=1) from inputs 0, 1, 2 all to port 2 → grant order 0, 1, 2. locked_o[2] stays 0 throughout. pointer[2] ends at 3.
3. Credits, BUFFER_SIZE=8: input 4 streams a 10-flit packet to port 0 with no credit_return_i → 8 grants, then grants_o stalls. One credit_return_i[0] pulse → exactly one more grant the following cycle.
4. In one cycle, grant to port 1 plus credit_return_i[1] → credits[1] unchanged. Credit return to idle port 4 at 8 credits → credit_err_o=1 next cycle and stays 1.
5. Parallel traffic: input 0→port 1 and input 3→port 4 with disjoint heads in the same cycle → both grants issued in that cycle. A head flit from input 0 toward port 2 while it owns port 1 → no grant.
6. Assert rst while port 3 is locked with credits[3]=2 → next cycle locked_o=0 and credits[3]=8. A new head flit from any input to port 3 is granted immediately.
